// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO peripheral: debounced inputs with edge IRQ, atomic output ops, 8-bit PWM
module gpio_ctrl #(
  parameter int          NIN     = 7,
  parameter int          NOUT    = 32,
  parameter int          NPWM    = 3,
  parameter int          DEB_CNT = 24000,
  parameter int          PWM_PRE = 94,
  parameter logic [31:0] OUT_RST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            we,
  input  logic [3:0]      addr,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  input  logic [NIN-1:0]  gp_in,
  output logic [NOUT-1:0] gp_out,
  output logic            irq
);
  localparam int CW  = $clog2(DEB_CNT);
  localparam int PW  = (PWM_PRE > 1) ? $clog2(PWM_PRE) : 1;
  localparam int NPA = (NPWM > 0) ? NPWM : 1;

  logic [NIN-1:0]  sync1, sync2, deb_q, deb_d, edge_q, edge_set, irq_en, edge_mode;
  logic [CW-1:0]   cnt_q [NIN];
  logic [CW-1:0]   cnt_d [NIN];
  logic [NOUT-1:0] out_q;
  logic [7:0]      duty [NPA];
  logic [NPA-1:0]  pwm_en;
  logic [PW-1:0]   pre;
  logic [7:0]      pwm_cnt;
  logic [31:0]     rdata;
  logic            wr, rd;

  assign wr = cs & we;
  assign rd = cs & ~we;

  // A bit is accepted only after differing from the debounced state for DEB_CNT consecutive cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (sync2[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CNT - 1)) deb_d[i] = sync2[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    edge_set = (deb_q ^ deb_d) & ~(deb_d ^ edge_mode);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb_q <= '1;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
    end else begin
      sync1 <= gp_in;
      sync2 <= sync1;
      deb_q <= deb_d;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= OUT_RST[NOUT-1:0];
      edge_q    <= '0;
      irq_en    <= '0;
      edge_mode <= '0;
      irq       <= 1'b0;
      pwm_en    <= '0;
      for (int k = 0; k < NPA; k++) duty[k] <= '0;
    end else begin
      if (wr) begin
        case (addr)
          4'd0: out_q <= din[NOUT-1:0];
          4'd1: out_q <= out_q | din[NOUT-1:0];
          4'd2: out_q <= out_q & ~din[NOUT-1:0];
          4'd3: out_q <= out_q ^ din[NOUT-1:0];
          4'd6: irq_en <= din[NIN-1:0];
          4'd7: edge_mode <= din[NIN-1:0];
          default: ;
        endcase
      end
      for (int k = 0; k < NPWM; k++) begin
        if (wr && addr == 4'(8 + k)) begin
          duty[k]   <= din[7:0];
          pwm_en[k] <= din[8];
        end
      end
      // New edges are OR-ed in after the W1C mask so a coincident set wins.
      edge_q <= (edge_q & ~((wr && addr == 4'd5) ? din[NIN-1:0] : '0)) | edge_set;
      irq    <= |(edge_q & irq_en);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre     <= '0;
      pwm_cnt <= '0;
      gp_out  <= OUT_RST[NOUT-1:0];
    end else begin
      if (pre == PW'(PWM_PRE - 1)) begin
        pre     <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        pre <= pre + PW'(1);
      end
      gp_out <= out_q;
      for (int k = 0; k < NPWM; k++) begin
        if (pwm_en[k]) gp_out[k] <= (pwm_cnt < duty[k]);
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      4'd0: rdata[NOUT-1:0] = out_q;
      4'd4: rdata[NIN-1:0]  = deb_q;
      4'd5: rdata[NIN-1:0]  = edge_q;
      4'd6: rdata[NIN-1:0]  = irq_en;
      4'd7: rdata[NIN-1:0]  = edge_mode;
      default: ;
    endcase
    for (int k = 0; k < NPWM; k++) begin
      if (addr == 4'(8 + k)) rdata[8:0] = {pwm_en[k], duty[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) dout <= '0;
    else if (rd) dout <= rdata;
  end
endmodule
